// File: rtl/apb_pwm_capture.sv
// apb_pwm_capture: APB slave that measures the period and active time of an
// external PWM waveform in pclk cycles, with W1C status and a level interrupt.
//
// APB handshake: a transfer is accepted in its setup cycle (psel & !penable).
// In that cycle a write updates its register, or a read loads prdata, and
// pready is registered high. pready is therefore high in the access cycle,
// completing every transfer with zero wait states. It then drops back to 0.
// prdata holds its value between reads.
module apb_pwm_capture (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic [7:0]  paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  input  logic [2:0]  pprot,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        pwm_in,
  output logic        irq
);

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_PERIOD  = 8'h08;
  localparam logic [7:0] ADDR_HIGH    = 8'h0C;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t      state;
  logic        ctrl_en;
  logic        ctrl_inv;
  logic        ctrl_irq_en;
  logic        st_valid;
  logic        st_missed;
  logic        st_stall;
  logic [31:0] period_q;
  logic [31:0] high_q;
  logic [31:0] timeout_q;
  logic [31:0] cnt;
  logic [31:0] hcnt;
  logic        s1;
  logic        s2;
  logic        s;
  logic        p;
  logic        rise;
  logic        setup;
  logic        wr_setup;
  logic [2:0]  w1c;
  logic [31:0] rdata;
  logic        timed_out;
  logic        unused_apb;

  // Byte strobes and protection are not used: every write is a full word.
  assign unused_apb = ^{pstrb, pprot};

  assign setup    = psel & ~penable;
  assign wr_setup = setup & pwrite;
  assign w1c      = (wr_setup && paddr == ADDR_STATUS) ? pwdata[2:0] : 3'b000;
  assign rise     = s & ~p;

  // Timeout of 0 disables the compare; the all-ones check is a hard stop so
  // the counters can never wrap.
  assign timed_out = ((timeout_q != 32'd0) && (cnt == timeout_q)) ||
                     (cnt == 32'hFFFF_FFFF);

  // Read data selection; unmapped addresses read as zero.
  always_comb begin
    rdata = 32'd0;
    case (paddr)
      ADDR_CTRL:    rdata = {29'd0, ctrl_irq_en, ctrl_inv, ctrl_en};
      ADDR_STATUS:  rdata = {29'd0, st_stall, st_missed, st_valid};
      ADDR_PERIOD:  rdata = period_q;
      ADDR_HIGH:    rdata = high_q;
      ADDR_TIMEOUT: rdata = timeout_q;
      default:      rdata = 32'd0;
    endcase
  end

  // APB register writes, read data capture and pready generation.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ctrl_en     <= 1'b0;
      ctrl_inv    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      timeout_q   <= 32'd0;
      prdata      <= 32'd0;
      pready      <= 1'b0;
    end else begin
      pready <= setup;
      if (setup) begin
        if (pwrite) begin
          if (paddr == ADDR_CTRL) begin
            ctrl_en     <= pwdata[0];
            ctrl_inv    <= pwdata[1];
            ctrl_irq_en <= pwdata[2];
          end else if (paddr == ADDR_TIMEOUT) begin
            timeout_q <= pwdata;
          end
        end else begin
          prdata <= rdata;
        end
      end
    end
  end

  // Input path: two-flop synchroniser, registered optional inversion, and the
  // delayed copy used for rising-edge detection.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s  <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s  <= s2 ^ ctrl_inv;
      p  <= s;
    end
  end

  // Measurement FSM with capture registers and STATUS. A hardware set in the
  // same cycle as a W1C of that bit wins, because the set is assigned last.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      hcnt      <= 32'd0;
      period_q  <= 32'd0;
      high_q    <= 32'd0;
      st_valid  <= 1'b0;
      st_missed <= 1'b0;
      st_stall  <= 1'b0;
    end else begin
      st_valid  <= st_valid  & ~w1c[0];
      st_missed <= st_missed & ~w1c[1];
      st_stall  <= st_stall  & ~w1c[2];
      if (!ctrl_en) begin
        state <= IDLE;
        cnt   <= 32'd0;
        hcnt  <= 32'd0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= 32'd1;
              hcnt  <= 32'd1;
              state <= MEAS;
            end
          end
          MEAS: begin
            if (rise) begin
              period_q  <= cnt;
              high_q    <= hcnt;
              st_valid  <= 1'b1;
              st_missed <= (st_missed & ~w1c[1]) | st_valid;
              cnt       <= 32'd1;
              hcnt      <= 32'd1;
            end else if (timed_out) begin
              st_stall <= 1'b1;
              state    <= ARM;
            end else begin
              cnt  <= cnt + 32'd1;
              hcnt <= hcnt + {31'd0, s};
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      irq <= 1'b0;
    end else begin
      irq <= ctrl_irq_en & (st_valid | st_stall);
    end
  end

endmodule

// File: tb/tb_apb_pwm_capture.sv
// tb_apb_pwm_capture: directed and randomized checks of apb_pwm_capture.
// Expected PERIOD/HIGH come from the waveform parameters the bench drives.
module tb_apb_pwm_capture;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic [7:0]  paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  wire         pwm_in;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // PWM source: a periodic generator or a manually driven level.
  bit   pwm_run    = 1'b0;
  logic gen_level  = 1'b0;
  logic man_level  = 1'b0;
  int   gen_period = 10;
  int   gen_high   = 3;
  int   gen_phase  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd;

  assign pwm_in = pwm_run ? gen_level : man_level;

  apb_pwm_capture dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pprot   (pprot),
    .prdata  (prdata),
    .pready  (pready),
    .pwm_in  (pwm_in),
    .irq     (irq)
  );

  // Clock
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Waveform generator: one phase step per cycle, level changes on negedge.
  always @(negedge pclk) begin
    if (pwm_run) begin
      gen_level = (gen_phase < gen_high);
      gen_phase = (gen_phase + 1 >= gen_period) ? 0 : gen_phase + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    check("pready_access_rd", {31'd0, pready}, 32'd1);
    d = prdata;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    check("pready_after_rd", {31'd0, pready}, 32'd0);
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    check("pready_access_wr", {31'd0, pready}, 32'd1);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("pready_after_wr", {31'd0, pready}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Drive ncyc generator cycles from phase 0, then hold stop_lvl.
  task automatic run_pwm(input int per, input int hi, input int ncyc, input logic stop_lvl);
    @(posedge pclk); #1;
    gen_period = per; gen_high = hi; gen_phase = 0; pwm_run = 1'b1;
    repeat (ncyc) @(negedge pclk);
    @(posedge pclk); #1;
    man_level = stop_lvl; pwm_run = 1'b0;
    wait_cycles(6);
  endtask

  // Reference: active time of one period as seen after optional inversion.
  function automatic logic [31:0] model_high(input int per, input int hi, input bit inv);
    return inv ? 32'(per - hi) : 32'(hi);
  endfunction

  initial begin
    int per;
    int hi;
    bit inv;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; paddr = 8'h00; pwrite = 1'b0;
    pwdata = 32'd0; pstrb = 4'hF; pprot = 3'b000;
    wait_cycles(3);
    preset = 1'b0;
    wait_cycles(1);

    // Reset state
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_pready", {31'd0, pready}, 32'd0);
    rd_chk("reset_ctrl", 8'h00, 32'd0);
    rd_chk("reset_status", 8'h04, 32'd0);
    rd_chk("reset_period", 8'h08, 32'd0);
    rd_chk("reset_high", 8'h0C, 32'd0);
    rd_chk("reset_timeout", 8'h10, 32'd0);
    rd_chk("unmapped_14", 8'h14, 32'd0);
    apb_wr(8'h08, 32'h1234);
    rd_chk("ro_period_ignored", 8'h08, 32'd0);

    // Basic capture 10/3 with irq
    apb_wr(8'h00, 32'h5);
    rd_chk("ctrl_rb", 8'h00, 32'h5);
    run_pwm(10, 3, 12, 1'b0);
    rd_chk("basic_period", 8'h08, 32'd10);
    rd_chk("basic_high", 8'h0C, 32'd3);
    rd_chk("basic_status", 8'h04, 32'h1);
    check("basic_irq", {31'd0, irq}, 32'd1);
    apb_wr(8'h04, 32'h1);
    wait_cycles(2);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk("status_cleared", 8'h04, 32'h0);

    // Inverted input measures low time
    apb_wr(8'h00, 32'h6);
    man_level = 1'b1;
    wait_cycles(6);
    apb_wr(8'h04, 32'h7);
    apb_wr(8'h00, 32'h7);
    run_pwm(10, 3, 15, 1'b1);
    rd_chk("inv_period", 8'h08, 32'd10);
    rd_chk("inv_high", 8'h0C, 32'd7);
    rd_chk("inv_status", 8'h04, 32'h1);

    // Timeout with input held active after one edge
    apb_wr(8'h10, 32'd20);
    apb_wr(8'h00, 32'h6);
    apb_wr(8'h00, 32'h7);
    apb_wr(8'h04, 32'h7);
    man_level = 1'b0;
    wait_cycles(30);
    rd_chk("timeout_status", 8'h04, 32'h4);
    rd_chk("timeout_period_kept", 8'h08, 32'd10);
    rd_chk("timeout_high_kept", 8'h0C, 32'd7);
    check("timeout_irq", {31'd0, irq}, 32'd1);
    run_pwm(8, 3, 13, 1'b1);
    rd_chk("resume_period", 8'h08, 32'd8);
    rd_chk("resume_high", 8'h0C, 32'd5);
    rd_chk("resume_status", 8'h04, 32'h5);
    apb_wr(8'h10, 32'd0);

    // Missed capture, then W1C colliding with a capture
    apb_wr(8'h00, 32'h4);
    man_level = 1'b0;
    wait_cycles(6);
    apb_wr(8'h04, 32'h7);
    apb_wr(8'h00, 32'h5);
    run_pwm(10, 3, 22, 1'b0);
    rd_chk("missed_status", 8'h04, 32'h3);
    rd_chk("missed_period", 8'h08, 32'd10);
    apb_wr(8'h04, 32'h3);
    rd_chk("w1c_both", 8'h04, 32'h0);
    @(negedge pclk); man_level = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h1;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0; man_level = 1'b0;
    rd_chk("set_beats_w1c", 8'h04, 32'h1);

    // Clearing en mid-period discards the partial measurement
    apb_wr(8'h00, 32'h1);
    man_level = 1'b1;
    wait_cycles(3);
    man_level = 1'b0;
    wait_cycles(3);
    apb_wr(8'h00, 32'h0);
    apb_wr(8'h04, 32'h7);
    apb_wr(8'h00, 32'h1);
    run_pwm(12, 4, 14, 1'b0);
    rd_chk("reen_period", 8'h08, 32'd12);
    rd_chk("reen_high", 8'h0C, 32'd4);
    rd_chk("reen_status", 8'h04, 32'h1);
    check("reen_irq_off", {31'd0, irq}, 32'd0);

    // Randomized waveforms against the reference model
    for (int i = 0; i < 8; i++) begin
      per = int'($urandom_range(40, 4));
      hi  = int'($urandom_range(per - 1, 1));
      inv = 1'($urandom_range(1, 0));
      apb_wr(8'h00, {29'd0, 1'b1, inv, 1'b0});
      man_level = inv;
      wait_cycles(6);
      apb_wr(8'h04, 32'h7);
      apb_wr(8'h00, {29'd0, 1'b1, inv, 1'b1});
      exp_q.push_back(32'(per));
      exp_q.push_back(model_high(per, hi, inv));
      run_pwm(per, hi, 3 * per, inv);
      apb_rd(8'h08, rd);
      check("rand_period", rd, exp_q.pop_front());
      apb_rd(8'h0C, rd);
      check("rand_high", rd, exp_q.pop_front());
      apb_rd(8'h04, rd);
      check("rand_valid", rd & 32'h1, 32'h1);
      check("rand_irq", {31'd0, irq}, 32'd1);
    end

    // Asynchronous reset in the middle of a measurement
    apb_wr(8'h10, 32'h1234);
    apb_wr(8'h00, 32'h5);
    @(posedge pclk); #1;
    gen_period = 9; gen_high = 4; gen_phase = 0; pwm_run = 1'b1;
    wait_cycles(15);
    #2 preset = 1'b1;
    #1 check("async_reset_irq", {31'd0, irq}, 32'd0);
    wait_cycles(2);
    preset = 1'b0;
    pwm_run = 1'b0;
    man_level = 1'b0;
    rd_chk("rst_ctrl", 8'h00, 32'd0);
    rd_chk("rst_status", 8'h04, 32'd0);
    rd_chk("rst_period", 8'h08, 32'd0);
    rd_chk("rst_high", 8'h0C, 32'd0);
    rd_chk("rst_timeout", 8'h10, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
